// File: rtl/hamming_enc_tx.sv
// Byte-to-Hamming(7,4) transmitter: each accepted byte leaves as two codewords,
// low nibble first, with an optional one-shot single-bit fault injection.
module hamming_enc_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        inj_arm,
    input  logic [2:0]  inj_pos,
    output logic        inj_pending,
    output logic [15:0] cw_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // valid never waits on ready, and the payload is held while valid && !ready.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        inj_pend_q, inj_pend_d;
    logic [2:0]  inj_pos_q, inj_pos_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_xfer;
    logic        out_xfer;
    logic [3:0]  nibble;
    logic [6:0]  clean_cw;
    logic [6:0]  inj_mask;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c    = '0;
        c[2] = d[3];
        c[4] = d[2];
        c[5] = d[1];
        c[6] = d[0];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            byte_q     <= '0;
            inj_pend_q <= 1'b0;
            inj_pos_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            inj_pend_q <= inj_pend_d;
            inj_pos_q  <= inj_pos_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_LO;
            S_LO:    if (out_xfer) state_d = S_HI;
            S_HI: begin
                if (out_xfer) state_d = in_xfer ? S_LO : S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        byte_d = in_xfer ? in_data : byte_q;
        cnt_d  = out_xfer ? cnt_q + 16'd1 : cnt_q;
    end

    // A new request wins over the clear, so a request coinciding with a
    // transfer only affects the following codeword.
    always_comb begin
        inj_pend_d = inj_pend_q;
        inj_pos_d  = inj_pos_q;
        if (inj_arm && inj_pos != 3'd7) begin
            inj_pend_d = 1'b1;
            inj_pos_d  = inj_pos;
        end else if (out_xfer) begin
            inj_pend_d = 1'b0;
        end
    end

    // Output logic: registered state and out_ready only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        nibble    = byte_q[3:0];
        case (state_q)
            S_EMPTY: in_ready = 1'b1;
            S_LO: begin
                out_valid = 1'b1;
                nibble    = byte_q[3:0];
            end
            S_HI: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                nibble    = byte_q[7:4];
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign clean_cw    = enc(nibble);
    assign inj_mask    = inj_pend_q ? (7'd1 << inj_pos_q) : 7'd0;
    assign out_data    = out_valid ? (clean_cw ^ inj_mask) : 7'd0;
    assign inj_pending = inj_pend_q;
    assign cw_count    = cnt_q;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Bench for hamming_enc_tx: directed scenarios plus random traffic, scored
// against a queue of expected codewords built from positional Hamming rules.
module tb_hamming_enc_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        inj_arm;
  logic [2:0]  inj_pos;
  logic        inj_pending;
  logic [15:0] cw_count;

  hamming_enc_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inj_arm    (inj_arm),
    .inj_pos    (inj_pos),
    .inj_pending(inj_pending),
    .cw_count   (cw_count)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [6:0]  exp_q[$];
  logic        m_pend;
  logic [2:0]  m_pos;
  logic [15:0] m_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // last observations from cycle()
  logic [6:0] last_d;
  logic       last_v;
  logic       last_rdy;
  logic       last_pend;
  logic       last_in_x;

  // codeword position p (1..7) lives in bit p-1; data d0..d3 sit at 7,6,5,3;
  // parity at position 1/2/4 covers every other position sharing that bit
  function automatic logic [6:0] enc_ref(input logic [3:0] d);
    int dpos[4];
    logic [6:0] cw;
    logic par;
    dpos = '{7, 6, 5, 3};
    cw = '0;
    for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= 7; q++)
        if ((q & p) != 0 && q != p) par = par ^ cw[q-1];
      cw[p-1] = par;
    end
    return cw;
  endfunction

  function automatic int syndrome(input logic [6:0] cw);
    int s;
    s = 0;
    for (int q = 1; q <= 7; q++) if (cw[q-1]) s = s ^ q;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = 1'b0;
    m_pos  = 3'd0;
    m_cnt  = 16'd0;
  endtask

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic cycle();
    logic ev, eir, out_x, in_x;
    logic [6:0] ed, mask;
    #1;
    ev   = (exp_q.size() != 0);
    eir  = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    mask = m_pend ? (7'd1 << m_pos) : 7'd0;
    ed   = ev ? (exp_q[0] ^ mask) : 7'd0;
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, eir);
    chk("out_data", out_data, ed);
    chk("inj_pending", inj_pending, m_pend);
    chk("cw_count", cw_count, m_cnt);
    last_d    = out_data;
    last_v    = out_valid;
    last_rdy  = in_ready;
    last_pend = inj_pending;
    out_x     = ev && out_ready;
    in_x      = in_valid && eir;
    last_in_x = in_x;
    @(posedge clk);
    if (out_x) begin
      void'(exp_q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (in_x) begin
      exp_q.push_back(enc_ref(in_data[3:0]));
      exp_q.push_back(enc_ref(in_data[7:4]));
    end
    if (inj_arm && inj_pos != 3'd7) begin
      m_pend = 1'b1;
      m_pos  = inj_pos;
    end else if (out_x) begin
      m_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    inj_arm   = 1'b0;
    inj_pos   = 3'd7;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_data"}, out_data, 7'h00);
    chk({tag, "_inj_pending"}, inj_pending, 1'b0);
    chk({tag, "_cw_count"}, cw_count, 16'h0000);
  endtask

  logic [7:0] bytes38[3];
  logic [6:0] seq38[6];
  int k;
  int idx;
  int syn;

  initial begin
    bytes38 = '{8'h00, 8'hFF, 8'h01};
    seq38   = '{7'h00, 7'h00, 7'h7F, 7'h7F, 7'h4B, 7'h00};
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 0xB8 -> 0x07, 0x66, count 2
    in_data = 8'hB8; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("b8_lo", last_d, 7'h07);
    cycle();
    chk("b8_hi", last_d, 7'h66);
    cycle();
    chk("b8_count", cw_count, 16'd2);

    // 0x00, 0xFF, 0x01 back to back
    k = 0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 3);
      in_data  = bytes38[(k < 3) ? k : 0];
      cycle();
      if (last_v && idx < 6) begin
        chk($sformatf("seq38_%0d", idx), last_d, seq38[idx]);
        idx++;
      end
      if (last_in_x) k++;
    end
    chk("seq38_words", idx, 6);
    in_valid = 1'b0;

    // back-pressure holds 0x07
    in_data = 8'hB8; in_valid = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = 8'($urandom_range(0, 255));
      cycle();
      chk("hold_data", last_d, 7'h07);
      chk("hold_ready", last_rdy, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("resume_lo", last_d, 7'h07);
    cycle();
    chk("resume_hi", last_d, 7'h66);

    // inject bit 2, then 0x0B
    inj_arm = 1'b1; inj_pos = 3'd2;
    cycle();
    inj_arm = 1'b0; inj_pos = 3'd7;
    in_data = 8'h0B; in_valid = 1'b1;
    cycle();
    chk("inj_armed", last_pend, 1'b1);
    in_valid = 1'b0;
    cycle();
    chk("inj_cw", last_d, 7'h62);
    syn = syndrome(last_d);
    chk("inj_syndrome", syn, 3);
    chk("inj_corrected", last_d ^ (7'd1 << (syn - 1)), 7'h66);
    cycle();
    chk("inj_cleared", last_pend, 1'b0);
    chk("inj_second", last_d, 7'h00);

    // inj_pos 7 is ignored
    inj_arm = 1'b1; inj_pos = 3'd7;
    in_data = 8'hB8; in_valid = 1'b1;
    cycle();
    inj_arm = 1'b0; in_valid = 1'b0;
    cycle();
    chk("pos7_pend", last_pend, 1'b0);
    chk("pos7_lo", last_d, 7'h07);
    cycle();
    chk("pos7_hi", last_d, 7'h66);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      inj_arm   = ($urandom_range(0, 9) == 0);
      inj_pos   = 3'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();

    // reset while in HI of 0xB8
    in_data = 8'hB8; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    inj_arm = 1'b1; inj_pos = 3'd4;
    cycle();
    inj_arm = 1'b0; inj_pos = 3'd7;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_hi");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("post_rst_idle", last_v, 1'b0);
    end
    in_data = 8'h3C; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("post_rst_lo", last_d, enc_ref(4'hC));

    // 65536 transfers wrap the counter
    rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 65537; c++) begin
      in_data = 8'($urandom_range(0, 255));
      cycle();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap_count", cw_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
